// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared definitions for the single-bus CPU datapath. Holds the
//               debug-dump slot offsets that follow the GPR slots and the
//               ALU operation encoding with its priority decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    // Slot offsets in regSelectStream, counted from slot REGISTERS.
    localparam int c_SLOT_OFS_HI    = 0;
    localparam int c_SLOT_OFS_LO    = 1;
    localparam int c_SLOT_OFS_ZHIGH = 2;
    localparam int c_SLOT_OFS_ZLOW  = 3;
    localparam int c_SLOT_OFS_PC    = 4;
    localparam int c_SLOT_OFS_MDR   = 5;
    localparam int c_NUM_EXTRA_SLOTS = 6;

    localparam int c_NUM_ALU_OPS = 13;

    // Encoding value equals the bit position in the select vector, so the
    // decoder can cast the winning index directly.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_MUL    = 4'd2,
        ALU_DIV    = 4'd3,
        ALU_SHR    = 4'd4,
        ALU_SHL    = 4'd5,
        ALU_ROR    = 4'd6,
        ALU_ROL    = 4'd7,
        ALU_AND    = 4'd8,
        ALU_OR     = 4'd9,
        ALU_NEGATE = 4'd10,
        ALU_NOT    = 4'd11,
        ALU_INCPC  = 4'd12,
        ALU_PASS   = 4'd13
    } alu_op_e;

    // Bit 0 (ADD) has the highest priority; scanning downward lets the
    // lowest set bit overwrite any higher one.
    function automatic alu_op_e alu_op_decode(input logic [c_NUM_ALU_OPS-1:0] sel);
        alu_op_e op;
        op = ALU_PASS;
        for (int i = c_NUM_ALU_OPS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                op = alu_op_e'(4'(i));
            end
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : datapath_alu
// Description : Combinational ALU. A comes from the RY latch, B from the bus.
//               Produces a 2*BITS result; most operations zero-extend.
// Ports       : i_a      [BITS]    operand A
//               i_b      [BITS]    operand B
//               i_op     alu_op_e  decoded operation
//               o_result [2*BITS]  result ({remainder, quotient} for DIV)
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0]   i_a,
    input  logic [BITS-1:0]   i_b,
    input  alu_op_e           i_op,
    output logic [2*BITS-1:0] o_result
);

    localparam int c_SH_W = $clog2(BITS);

    logic [c_SH_W-1:0]        w_sh;
    logic signed [2*BITS-1:0] w_a_wide;
    logic signed [2*BITS-1:0] w_b_wide;
    logic signed [2*BITS-1:0] w_prod;
    logic signed [BITS:0]     w_a_div;
    logic signed [BITS:0]     w_b_div;
    logic signed [BITS:0]     w_quot;
    logic signed [BITS:0]     w_rem;
    logic                     w_b_zero;
    logic [2*BITS-1:0]        w_rol_dbl;
    logic [2*BITS-1:0]        w_ror_dbl;
    logic                     w_unused;

    assign w_sh     = i_b[c_SH_W-1:0];
    assign w_a_wide = {{BITS{i_a[BITS-1]}}, i_a};
    assign w_b_wide = {{BITS{i_b[BITS-1]}}, i_b};
    assign w_prod   = w_a_wide * w_b_wide;

    // One extra bit keeps MIN / -1 representable; the divisor is forced to 1
    // when zero so the divider never sees a zero operand.
    assign w_b_zero = (i_b == '0);
    assign w_a_div  = {i_a[BITS-1], i_a};
    assign w_b_div  = w_b_zero ? (BITS+1)'(1) : {i_b[BITS-1], i_b};
    assign w_quot   = w_a_div / w_b_div;
    assign w_rem    = w_a_div % w_b_div;

    // Rotates: shift a doubled copy and keep the half that wraps around.
    assign w_rol_dbl = {i_a, i_a} << w_sh;
    assign w_ror_dbl = {i_a, i_a} >> w_sh;

    assign w_unused = ^{w_rol_dbl[BITS-1:0], w_ror_dbl[2*BITS-1:BITS],
                        w_quot[BITS], w_rem[BITS]};

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:    o_result = {{BITS{1'b0}}, i_a + i_b};
            ALU_SUB:    o_result = {{BITS{1'b0}}, i_a - i_b};
            ALU_MUL:    o_result = w_prod;
            ALU_DIV:    o_result = w_b_zero ? {i_a, {BITS{1'b1}}}
                                            : {w_rem[BITS-1:0], w_quot[BITS-1:0]};
            ALU_SHR:    o_result = {{BITS{1'b0}}, i_a >> w_sh};
            ALU_SHL:    o_result = {{BITS{1'b0}}, i_a << w_sh};
            ALU_ROR:    o_result = {{BITS{1'b0}}, w_ror_dbl[BITS-1:0]};
            ALU_ROL:    o_result = {{BITS{1'b0}}, w_rol_dbl[2*BITS-1:BITS]};
            ALU_AND:    o_result = {{BITS{1'b0}}, i_a & i_b};
            ALU_OR:     o_result = {{BITS{1'b0}}, i_a | i_b};
            ALU_NEGATE: o_result = {{BITS{1'b0}}, -i_b};
            ALU_NOT:    o_result = {{BITS{1'b0}}, ~i_b};
            ALU_INCPC:  o_result = {{BITS{1'b0}}, i_b + 1'b1};
            default:    o_result = {{BITS{1'b0}}, i_b};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module      : datapath
// Description : Single-bus CPU datapath: GPR file, PC, IR, MDR, MAR, HI, LO,
//               ALU input latch RY and 2*BITS result register RZ, all sharing
//               one priority-muxed bus.
// Ports       : reset, Clock            synchronous active-high reset, clock
//               GPRin/GPRout            per-GPR load / drive enables
//               PCin..MDRin             register load enables
//               Read                    MDR source: 1 = Mdatain, 0 = bus
//               MDRout..PCout           bus drive enables
//               ADD..IncPC              ALU operation selects (ADD highest)
//               Mdatain                 memory read data
//               regSelectStream         register dump (GPRs, HI, LO, Zh, Zl, PC, MDR)
//               bus, MARVal, RZVal, IRVal  live register/bus values
// Options     : DATAPATH_R0_ZERO_EN - when defined GPR0 is hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath
    import datapath_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                                    reset,
    input  logic                                    Clock,
    input  logic [REGISTERS-1:0]                    GPRin,
    input  logic                                    PCin,
    input  logic                                    IRin,
    input  logic                                    RYin,
    input  logic                                    RZin,
    input  logic                                    MARin,
    input  logic                                    HIin,
    input  logic                                    LOin,
    input  logic                                    MDRin,
    input  logic                                    Read,
    input  logic                                    MDRout,
    input  logic                                    LOout,
    input  logic                                    HIout,
    input  logic                                    Zhighout,
    input  logic                                    Zlowout,
    input  logic                                    PCout,
    input  logic [REGISTERS-1:0]                    GPRout,
    input  logic                                    ADD,
    input  logic                                    SUB,
    input  logic                                    MUL,
    input  logic                                    DIV,
    input  logic                                    SHR,
    input  logic                                    SHL,
    input  logic                                    ROR,
    input  logic                                    ROL,
    input  logic                                    AND,
    input  logic                                    OR,
    input  logic                                    NEGATE,
    input  logic                                    NOT,
    input  logic                                    IncPC,
    input  logic [BITS-1:0]                         Mdatain,
    output logic [BITS*(REGISTERS+c_NUM_EXTRA_SLOTS)-1:0] regSelectStream,
    output logic [BITS-1:0]                         bus,
    output logic [BITS-1:0]                         MARVal,
    output logic [2*BITS-1:0]                       RZVal,
    output logic [BITS-1:0]                         IRVal
);

`ifdef DATAPATH_R0_ZERO_EN
    localparam bit c_R0_ZERO = 1'b1;
`else
    localparam bit c_R0_ZERO = 1'b0;
`endif

    logic [BITS-1:0]   r_pc;
    logic [BITS-1:0]   r_ir;
    logic [BITS-1:0]   r_ry;
    logic [2*BITS-1:0] r_rz;
    logic [BITS-1:0]   r_mar;
    logic [BITS-1:0]   r_hi;
    logic [BITS-1:0]   r_lo;
    logic [BITS-1:0]   r_mdr;

    logic [BITS-1:0]   w_gpr [REGISTERS];
    logic [BITS-1:0]   w_bus;
    logic [2*BITS-1:0] w_alu_result;
    logic [c_NUM_ALU_OPS-1:0] w_op_sel;
    alu_op_e           w_op;

    // ------------------------------------------------------------------
    // General-purpose registers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < REGISTERS; gi++) begin : g_gpr
        if (c_R0_ZERO && gi == 0) begin : g_hardwired
            logic w_unused_load;
            assign w_unused_load = GPRin[gi];
            assign w_gpr[gi]     = '0;
        end else begin : g_reg
            logic [BITS-1:0] r_q;
            always_ff @(posedge Clock) begin
                if (reset) begin
                    r_q <= '0;
                end else if (GPRin[gi]) begin
                    r_q <= w_bus;
                end
            end
            assign w_gpr[gi] = r_q;
        end
    end

    // ------------------------------------------------------------------
    // Bus mux: fixed priority, GPR scan downward so the lowest index wins
    // ------------------------------------------------------------------
    always_comb begin
        w_bus = '0;
        if (MDRout) begin
            w_bus = r_mdr;
        end else if (PCout) begin
            w_bus = r_pc;
        end else if (Zlowout) begin
            w_bus = r_rz[BITS-1:0];
        end else if (Zhighout) begin
            w_bus = r_rz[2*BITS-1:BITS];
        end else if (HIout) begin
            w_bus = r_hi;
        end else if (LOout) begin
            w_bus = r_lo;
        end else begin
            for (int i = REGISTERS - 1; i >= 0; i--) begin
                if (GPRout[i]) begin
                    w_bus = w_gpr[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign w_op_sel = {IncPC, NOT, NEGATE, OR, AND, ROL, ROR,
                       SHL, SHR, DIV, MUL, SUB, ADD};
    assign w_op     = alu_op_decode(w_op_sel);

    datapath_alu #(
        .BITS (BITS)
    ) u_alu (
        .i_a      (r_ry),
        .i_b      (w_bus),
        .i_op     (w_op),
        .o_result (w_alu_result)
    );

    // ------------------------------------------------------------------
    // Special registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_ry  <= '0;
            r_rz  <= '0;
            r_mar <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_mdr <= '0;
        end else begin
            if (PCin)  r_pc  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (RYin)  r_ry  <= w_bus;
            if (RZin)  r_rz  <= w_alu_result;
            if (MARin) r_mar <= w_bus;
            if (HIin)  r_hi  <= w_bus;
            if (LOin)  r_lo  <= w_bus;
            if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus    = w_bus;
    assign MARVal = r_mar;
    assign RZVal  = r_rz;
    assign IRVal  = r_ir;

    for (genvar gk = 0; gk < REGISTERS; gk++) begin : g_dump
        assign regSelectStream[BITS*gk +: BITS] = w_gpr[gk];
    end

    assign regSelectStream[BITS*(REGISTERS+c_SLOT_OFS_HI)    +: BITS] = r_hi;
    assign regSelectStream[BITS*(REGISTERS+c_SLOT_OFS_LO)    +: BITS] = r_lo;
    assign regSelectStream[BITS*(REGISTERS+c_SLOT_OFS_ZHIGH) +: BITS] = r_rz[2*BITS-1:BITS];
    assign regSelectStream[BITS*(REGISTERS+c_SLOT_OFS_ZLOW)  +: BITS] = r_rz[BITS-1:0];
    assign regSelectStream[BITS*(REGISTERS+c_SLOT_OFS_PC)    +: BITS] = r_pc;
    assign regSelectStream[BITS*(REGISTERS+c_SLOT_OFS_MDR)   +: BITS] = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath
// Description : Self-checking bench for datapath. A behavioural model of the
//               register set is compared against the DUT on every falling
//               edge; directed sequences pin the model with literal values,
//               then randomized strobes exercise everything together.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

    localparam int BITS  = 32;
    localparam int REGS  = 16;
    localparam int NSLOT = REGS + 6;
    // Slot numbers for the six trailing dump entries.
    localparam int S_HI = REGS, S_LO = REGS + 1, S_ZH = REGS + 2;
    localparam int S_ZL = REGS + 3, S_PC = REGS + 4, S_MDR = REGS + 5;

`ifdef DATAPATH_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    // ops bits: 0 ADD 1 SUB 2 MUL 3 DIV 4 SHR 5 SHL 6 ROR 7 ROL
    //           8 AND 9 OR 10 NEGATE 11 NOT 12 IncPC
    // drv bits (priority order): 0 MDR 1 PC 2 Zlow 3 Zhigh 4 HI 5 LO
    // ld bits: 0 PC 1 IR 2 RY 3 RZ 4 MAR 5 HI 6 LO 7 MDR
    logic            Clock = 1'b0;
    logic            reset;
    logic [REGS-1:0] GPRin, GPRout;
    logic [7:0]      ld;
    logic [5:0]      drv;
    logic [12:0]     ops;
    logic            Read;
    logic [BITS-1:0] Mdatain;

    logic [BITS*NSLOT-1:0] stream;
    logic [BITS-1:0]       bus, MARVal, IRVal;
    logic [2*BITS-1:0]     RZVal;

    int  n_vec = 0;
    int  n_err = 0;
    bit  checking = 1'b0;

    datapath #(.BITS(BITS), .REGISTERS(REGS)) dut (
        .reset(reset), .Clock(Clock), .GPRin(GPRin),
        .PCin(ld[0]), .IRin(ld[1]), .RYin(ld[2]), .RZin(ld[3]),
        .MARin(ld[4]), .HIin(ld[5]), .LOin(ld[6]), .MDRin(ld[7]),
        .Read(Read),
        .MDRout(drv[0]), .LOout(drv[5]), .HIout(drv[4]), .Zhighout(drv[3]),
        .Zlowout(drv[2]), .PCout(drv[1]), .GPRout(GPRout),
        .ADD(ops[0]), .SUB(ops[1]), .MUL(ops[2]), .DIV(ops[3]), .SHR(ops[4]),
        .SHL(ops[5]), .ROR(ops[6]), .ROL(ops[7]), .AND(ops[8]), .OR(ops[9]),
        .NEGATE(ops[10]), .NOT(ops[11]), .IncPC(ops[12]),
        .Mdatain(Mdatain), .regSelectStream(stream), .bus(bus),
        .MARVal(MARVal), .RZVal(RZVal), .IRVal(IRVal)
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural model ----------------
    logic [31:0] m_gpr [REGS];
    logic [31:0] m_pc, m_ir, m_ry, m_mar, m_hi, m_lo, m_mdr;
    logic [63:0] m_rz;

    function automatic logic [31:0] m_bus();
        if (drv[0]) return m_mdr;
        if (drv[1]) return m_pc;
        if (drv[2]) return m_rz[31:0];
        if (drv[3]) return m_rz[63:32];
        if (drv[4]) return m_hi;
        if (drv[5]) return m_lo;
        for (int i = 0; i < REGS; i++)
            if (GPRout[i]) return m_gpr[i];
        return 32'h0;
    endfunction

    function automatic int m_op();
        for (int i = 0; i < 13; i++)
            if (ops[i]) return i;
        return 13;
    endfunction

    function automatic logic [63:0] m_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic [31:0] t;
        longint      sa, sb, p, q, r;
        s  = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0:  t = a + b;
            1:  t = a - b;
            2:  begin p = sa * sb; return p; end
            3:  begin
                    if (b == 0) return {a, 32'hFFFF_FFFF};
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
            4:  t = a >> s;
            5:  t = a << s;
            6:  t = (a >> s) | (a << (32 - s));
            7:  t = (a << s) | (a >> (32 - s));
            8:  t = a & b;
            9:  t = a | b;
            10: t = 32'h0 - b;
            11: t = ~b;
            12: t = b + 1;
            default: t = b;
        endcase
        return {32'h0, t};
    endfunction

    function automatic logic [31:0] m_slot(input int k);
        if (k < REGS) return m_gpr[k];
        case (k)
            S_HI: return m_hi;
            S_LO: return m_lo;
            S_ZH: return m_rz[63:32];
            S_ZL: return m_rz[31:0];
            S_PC: return m_pc;
            default: return m_mdr;
        endcase
    endfunction

    always @(posedge Clock) begin
        logic [31:0] b;
        logic [63:0] res;
        b   = m_bus();
        res = m_alu(m_op(), m_ry, b);
        if (reset) begin
            for (int i = 0; i < REGS; i++) m_gpr[i] = '0;
            m_pc = '0; m_ir = '0; m_ry = '0; m_rz = '0;
            m_mar = '0; m_hi = '0; m_lo = '0; m_mdr = '0;
            checking = 1'b1;
        end else begin
            for (int i = 0; i < REGS; i++)
                if (GPRin[i] && !(R0Z && i == 0)) m_gpr[i] = b;
            if (ld[0]) m_pc  = b;
            if (ld[1]) m_ir  = b;
            if (ld[2]) m_ry  = b;
            if (ld[3]) m_rz  = res;
            if (ld[4]) m_mar = b;
            if (ld[5]) m_hi  = b;
            if (ld[6]) m_lo  = b;
            if (ld[7]) m_mdr = Read ? Mdatain : b;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge once the model has been reset.
    always @(negedge Clock) begin
        if (checking) begin
            chk("bus", {32'h0, bus}, {32'h0, m_bus()});
            chk("MARVal", {32'h0, MARVal}, {32'h0, m_mar});
            chk("IRVal", {32'h0, IRVal}, {32'h0, m_ir});
            chk("RZVal", RZVal, m_rz);
            for (int k = 0; k < NSLOT; k++)
                chk($sformatf("slot%0d", k), {32'h0, stream[BITS*k +: BITS]}, {32'h0, m_slot(k)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        reset = 1'b0; GPRin = '0; GPRout = '0; ld = '0; drv = '0;
        ops = '0; Read = 1'b0; Mdatain = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic put_mdr(input logic [31:0] v);
        idle(); Mdatain = v; Read = 1'b1; ld[7] = 1'b1;
        tick();
    endtask

    task automatic load_gpr(input int idx, input logic [31:0] v);
        put_mdr(v);
        idle(); drv[0] = 1'b1; GPRin[idx] = 1'b1;
        tick();
    endtask

    task automatic load_ry(input logic [31:0] v);
        put_mdr(v);
        idle(); drv[0] = 1'b1; ld[2] = 1'b1;
        tick();
    endtask

    // RZ <= RY op v, then leaves the inputs idle and settled.
    task automatic alu_mdr(input int opbit, input logic [31:0] v);
        put_mdr(v);
        idle(); drv[0] = 1'b1; ops[opbit] = 1'b1; ld[3] = 1'b1;
        tick();
        idle();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        // Reset with random strobes asserted: reset must win.
        reset = 1'b1; GPRin = 16'($urandom); GPRout = 16'($urandom);
        ld = 8'($urandom); drv = 6'($urandom); ops = 13'($urandom);
        Read = 1'b1; Mdatain = $urandom;
        tick();
        idle(); #1;
        chk("reset_bus", {32'h0, bus}, 64'h0);
        chk("reset_rz", RZVal, 64'h0);
        chk("reset_mar", {32'h0, MARVal}, 64'h0);
        chk("reset_ir", {32'h0, IRVal}, 64'h0);
        for (int k = 0; k < NSLOT; k++)
            chk($sformatf("reset_slot%0d", k), {32'h0, stream[BITS*k +: BITS]}, 64'h0);

        // MDR -> R2
        idle(); Mdatain = 32'h22; Read = 1'b1; ld[7] = 1'b1; drv[0] = 1'b1; GPRin[2] = 1'b1;
        tick(); #1;
        chk("mdr_load", {32'h0, stream[BITS*S_MDR +: BITS]}, 64'h22);
        chk("mdr_bus", {32'h0, bus}, 64'h22);
        ld[7] = 1'b0;
        tick(); #1;
        chk("r2_load", {32'h0, stream[BITS*2 +: BITS]}, 64'h22);

        // ADD path: R3=5 -> RY, R4=7 on bus
        load_gpr(3, 32'd5);
        load_gpr(4, 32'd7);
        idle(); GPRout[3] = 1'b1; ld[2] = 1'b1;
        tick();
        idle(); GPRout[4] = 1'b1; ops[0] = 1'b1; ld[3] = 1'b1;
        tick();
        idle(); drv[2] = 1'b1; #1;
        chk("add_rz", RZVal, 64'd12);
        chk("add_zlow_bus", {32'h0, bus}, 64'd12);

        // MUL / DIV with RY = -6
        load_ry(32'hFFFF_FFFA);
        alu_mdr(2, 32'd4);
        chk("mul", RZVal, 64'hFFFF_FFFF_FFFF_FFE8);
        alu_mdr(3, 32'd4);
        chk("div", RZVal, 64'hFFFF_FFFE_FFFF_FFFF);
        alu_mdr(3, 32'd0);
        chk("div_zero", RZVal, 64'hFFFF_FFFA_FFFF_FFFF);

        // Shifts and rotates
        load_ry(32'h8000_0001);
        alu_mdr(7, 32'd1); chk("rol", RZVal, 64'h0000_0003);
        alu_mdr(6, 32'd1); chk("ror", RZVal, 64'hC000_0000);
        alu_mdr(4, 32'd1); chk("shr", RZVal, 64'h4000_0000);
        alu_mdr(5, 32'd1); chk("shl", RZVal, 64'h0000_0002);

        // Bus priority and idle bus
        put_mdr(32'h100);
        idle(); drv[0] = 1'b1; ld[0] = 1'b1;
        tick();
        load_gpr(1, 32'h55);
        idle(); drv[1] = 1'b1; GPRout[1] = 1'b1; #1;
        chk("prio_pc_over_gpr", {32'h0, bus}, 64'h100);
        idle(); #1;
        chk("idle_bus", {32'h0, bus}, 64'h0);

        // IncPC
        idle(); drv[1] = 1'b1; ops[12] = 1'b1; ld[3] = 1'b1;
        tick();
        idle(); drv[2] = 1'b1; ld[0] = 1'b1;
        tick();
        idle(); #1;
        chk("incpc", {32'h0, stream[BITS*S_PC +: BITS]}, 64'h101);

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < 6; i++)  drv[i]    = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < REGS; i++) GPRout[i] = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < 8; i++)  ld[i]     = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < REGS; i++) GPRin[i]  = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 13; i++) ops[i]    = ($urandom_range(0, 7) == 0);
            Read = 1'($urandom);
            case ($urandom_range(0, 3))
                0: Mdatain = 32'h0;
                1: Mdatain = 32'($urandom_range(0, 40));
                2: Mdatain = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                default: Mdatain = $urandom;
            endcase
            tick();
        end

        idle();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath.md
Name: datapath

Overview:
- Single-bus CPU datapath for the Phase-1 bus architecture.
- Contains a general-purpose register file, PC, IR, MDR, MAR, HI, LO, the ALU input latch RY and the 64-bit ALU result register RZ.
- All sources share one BITS-wide bus selected by *out strobes. Sinks load from the bus on *in strobes. The ALU computes from RY and the bus into RZ.
- The control unit (a testbench in Phase 1) drives every strobe.

Parameters:
- BITS, 32, data width of the bus and of every register.
- REGISTERS, 16, number of general-purpose registers.

Ports:
- reset  input  1  synchronous, active-high; clears every register.
- Clock  input  1  single clock; all state updates on its rising edge.
- GPRin  input  REGISTERS  one-hot load enables, GPR[i] <= bus.
- PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin  input  1 each  load enables for those registers.
- Read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
- MDRout, LOout, HIout, Zhighout, Zlowout, PCout  input  1 each  bus drive enables.
- GPRout  input  REGISTERS  GPR bus drive enables.
- ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC  input  1 each  ALU operation selects.
- Mdatain  input  BITS  memory read data.
- regSelectStream  output  BITS*(REGISTERS+6)  debug dump of register contents.
  - Slot k occupies bits [BITS*k +: BITS].
  - Slots 0..REGISTERS-1 are GPR0..GPRn.
  - The next six slots, in order: HI, LO, Zhigh, Zlow, PC, MDR.
- bus  output  BITS  current bus value.
- MARVal  output  BITS  MAR contents.
- RZVal  output  2*BITS  RZ contents, high half on top.
- IRVal  output  BITS  IR contents.

Behaviour:
- Reset: synchronous and active-high. On a rising Clock edge with reset=1, every register (GPRs, PC, IR, RY, RZ, MAR, HI, LO, MDR) becomes 0. Reset overrides all load enables.
- Bus (combinational):
  - Bus carries the selected source.
  - Priority when more than one drive enable is asserted: MDRout > PCout > Zlowout > Zhighout > HIout > LOout > GPRout (lowest GPR index wins).
  - No drive enable asserted: bus = 0.
- Register loads: on a rising edge, each register whose *in strobe is high takes the bus value, except:
  - MDR takes Mdatain when Read=1, else the bus.
  - RZ takes the 2*BITS ALU result.
- Load latency: one edge. A value driven on the bus is visible in the destination after the next rising edge.
- Read-old semantics: a register driven and loaded in the same cycle keeps read-old behaviour, i.e. the bus shows the pre-edge value.
- ALU (combinational), with A = RY and B = bus. Result is 2*BITS wide and zero-extended unless noted:
  - ADD: A+B, wraps mod 2^BITS.
  - SUB: A-B, wraps mod 2^BITS.
  - MUL: signed A*B, full 2*BITS product.
  - DIV: signed; low half = quotient, high half = remainder (sign follows dividend).
  - DIV with B=0: low half = all ones, high half = A.
  - SHR (logical), SHL, ROR, ROL: shift/rotate A by B[$clog2(BITS)-1:0].
  - AND, OR: bitwise A, B.
  - NEGATE: -B.
  - NOT: ~B.
  - IncPC: B+1.
- Op selection priority: in the listed port order, ADD highest, IncPC lowest.
- No op asserted: result = B zero-extended.
- Outputs MARVal, IRVal, RZVal and regSelectStream are continuous register reads with no added latency.

Optional Feature:
- Macro DATAPATH_R0_ZERO_EN.
- Defined: GPR0 is hardwired to 0. GPRin[0] is ignored, and GPR0 reads 0 on the bus and in regSelectStream.
- Undefined: GPR0 is an ordinary register.

Decomposition:
- Package datapath_pkg holds:
  - the slot-index constants for HI, LO, Zhigh, Zlow, PC, MDR (offsets REGISTERS+0..+5);
  - the ALU operation enum and its priority encoding.
- One sub-module, datapath_alu: combinational, inputs A, B and op; output 2*BITS result.
- Register file, bus mux and control decoding stay in datapath.

Test Plan:
- Reset: hold reset=1 across an edge with random strobes -> every register and every regSelectStream slot reads 0.
- MDR to R2 transfer:
  - Stimulus: after reset, Mdatain=0x22, Read=1, MDRin=1, MDRout=1, GPRin[2]=1.
  - After edge 1: MDR=0x22 and bus=0x22.
  - Drop MDRin; after edge 2: R2=0x22 (slot 2 of regSelectStream).
- ADD path: R3=5 loaded into RY, R4=7 driven on bus with ADD and RZin -> RZVal=12; Zlowout then drives 12 onto the bus.
- MUL/DIV:
  - RY=-6 (0xFFFFFFFA), bus=4, MUL -> RZVal = 64-bit -24.
  - DIV with bus=4 -> low half 0xFFFFFFFF (-1), high half 0xFFFFFFFE (-2).
  - DIV with bus=0 -> low half all ones, high half = RY.
- Shifts and rotates: RY=0x80000001, bus=1 -> ROL=0x00000003, ROR=0xC0000000, SHR=0x40000000, SHL=0x00000002.
- Bus priority and idle: PCout and GPRout[1] asserted together -> bus=PC; no drive enables -> bus=0.
- IncPC: PCout, IncPC, RZin, then Zlowout with PCin -> PC increments by 1.
